// File: rtl/axis_buf_pkg.sv
// Shared sizing helpers and the storage-word layout for axis_stream_buffer.
package axis_buf_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_ADDR_WIDTH = 12;

   function automatic int unsigned buf_depth(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

   function automatic int unsigned buf_strb_width(input int unsigned data_width);
      return data_width / 8;
   endfunction

   // Storage word at the default data width: {tlast, tstrb, tdata}
   typedef struct packed {
      logic                        tlast;
      logic [DEF_DATA_WIDTH/8-1:0] tstrb;
      logic [DEF_DATA_WIDTH-1:0]   tdata;
   } buf_word_t;

endpackage

// File: rtl/axis_buf_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no array reset.
module axis_buf_ram
   import axis_buf_pkg::*;
#(
   parameter int unsigned WIDTH      = 37,
   parameter int unsigned ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   localparam int unsigned DEPTH = buf_depth(ADDR_WIDTH);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/axis_stream_buffer.sv
// AXI4-Stream buffer: sync-read RAM, read stage and one output register (FWFT).
// Define AXIS_BUF_PKT_MODE_EN for store-and-forward packet gating.
module axis_stream_buffer
   import axis_buf_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 12,
   parameter int unsigned ALMOST_FULL_TH = buf_depth(ADDR_WIDTH) - 4
) (
   input  logic                    axis_aclk,
   input  logic                    axis_areset,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   output logic [ADDR_WIDTH:0]     fill_level,
   output logic                    almost_full
);

   localparam int unsigned DEPTH  = buf_depth(ADDR_WIDTH);
   localparam int unsigned STRB_W = buf_strb_width(DATA_WIDTH);
   localparam int unsigned WORD_W = DATA_WIDTH + STRB_W + 1;
   localparam int unsigned CNT_W  = ADDR_WIDTH + 1;

   typedef struct packed {
      logic                  tlast;
      logic [STRB_W-1:0]     tstrb;
      logic [DATA_WIDTH-1:0] tdata;
   } word_t;

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      count_nxt;
   logic [CNT_W-1:0]      ram_cnt;
   logic [CNT_W-1:0]      ram_cnt_nxt;
   logic                  q_valid;
   logic [WORD_W-1:0]     ram_q;
   word_t                 wr_word;
   word_t                 q_word;
   logic                  wr_hs;
   logic                  rd_hs;
   logic                  ram_rd;
   logic                  load_out;
   logic                  load_ok;

   assign wr_word  = '{tlast: s_axis_tlast, tstrb: s_axis_tstrb, tdata: s_axis_tdata};
   assign q_word   = ram_q;
   assign wr_hs    = s_axis_tvalid && s_axis_tready;
   assign rd_hs    = m_axis_tvalid && m_axis_tready;
   // Output register refills when empty or being drained the same cycle
   assign load_out = q_valid && load_ok && (!m_axis_tvalid || m_axis_tready);
   assign ram_rd   = (ram_cnt != '0) && (!q_valid || load_out);
   assign fill_level = count;

   axis_buf_ram #(
      .WIDTH      (WORD_W),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (axis_aclk),
      .wr_en   (wr_hs),
      .wr_addr (wr_ptr),
      .wr_data (wr_word),
      .rd_en   (ram_rd),
      .rd_addr (rd_ptr),
      .rd_data (ram_q)
   );

   // Total occupancy and words still sitting in the RAM array
   always_comb begin
      count_nxt   = count;
      ram_cnt_nxt = ram_cnt;
      if (wr_hs && !rd_hs)      count_nxt = count + CNT_W'(1);
      else if (!wr_hs && rd_hs) count_nxt = count - CNT_W'(1);
      if (wr_hs && !ram_rd)      ram_cnt_nxt = ram_cnt + CNT_W'(1);
      else if (!wr_hs && ram_rd) ram_cnt_nxt = ram_cnt - CNT_W'(1);
   end

`ifdef AXIS_BUF_PKT_MODE_EN
   logic [CNT_W-1:0] pkt_count;
   logic [CNT_W-1:0] pkt_held;
   logic             sop;
   logic             pkt_in;
   logic             pkt_out;

   assign pkt_in   = wr_hs && s_axis_tlast;
   assign pkt_out  = rd_hs && m_axis_tlast;
   // A tlast beat still parked in the output register does not release the next packet
   assign pkt_held = CNT_W'(m_axis_tvalid && m_axis_tlast);
   assign load_ok  = !sop || (pkt_count > pkt_held) || (count == CNT_W'(DEPTH));

   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         pkt_count <= '0;
         sop       <= 1'b1;
      end else begin
         if (pkt_in && !pkt_out)      pkt_count <= pkt_count + CNT_W'(1);
         else if (!pkt_in && pkt_out) pkt_count <= pkt_count - CNT_W'(1);
         if (load_out) sop <= q_word.tlast;
      end
   end
`else
   assign load_ok = 1'b1;
`endif

   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         ram_cnt       <= '0;
         q_valid       <= 1'b0;
         s_axis_tready <= 1'b0;
         almost_full   <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tstrb  <= '0;
         m_axis_tlast  <= 1'b0;
      end else begin
         count         <= count_nxt;
         ram_cnt       <= ram_cnt_nxt;
         s_axis_tready <= (count_nxt < CNT_W'(DEPTH));
         almost_full   <= (count_nxt >= CNT_W'(ALMOST_FULL_TH));
         if (wr_hs)  wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (ram_rd) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         if (ram_rd)        q_valid <= 1'b1;
         else if (load_out) q_valid <= 1'b0;
         if (load_out) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= q_word.tdata;
            m_axis_tstrb  <= q_word.tstrb;
            m_axis_tlast  <= q_word.tlast;
         end else if (rd_hs) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axis_stream_buffer.sv
// Directed bench for axis_stream_buffer: vector table plus multi-cycle sequences and a scoreboard.
module tb_axis_stream_buffer;
   import axis_buf_pkg::*;

   localparam int unsigned AW = DEF_ADDR_WIDTH;
   localparam int DEPTH = int'(buf_depth(AW));
   localparam int AF_TH = DEPTH - 4;

   typedef struct {
      logic [31:0] in_data;
      logic [3:0]  in_strb;
      logic        in_last;
      logic [31:0] exp_data;
      logic [3:0]  exp_strb;
      logic        exp_last;
   } vec_t;

   logic        clk;
   logic        axis_areset;
   logic [31:0] s_axis_tdata;
   logic [3:0]  s_axis_tstrb;
   logic        s_axis_tvalid;
   logic        s_axis_tlast;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic [3:0]  m_axis_tstrb;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_tready;
   logic [12:0] fill_level;
   logic        almost_full;

   int n_pass;
   int n_total;
   int cyc;
   int model_cnt;
   int first_acc;
   int first_val;
   logic mon_en;
   logic hold_prev;
   buf_word_t prev_word;
   buf_word_t exp_q[$];
   buf_word_t got_q[$];

   axis_stream_buffer dut (
      .axis_aclk     (clk),
      .axis_areset   (axis_areset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tstrb  (s_axis_tstrb),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tstrb  (m_axis_tstrb),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .fill_level    (fill_level),
      .almost_full   (almost_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, got time %0t required < 5000000", $time);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic buf_word_t mk(input logic [31:0] d, input logic [3:0] s, input logic l);
      buf_word_t w;
      w = {l, s, d};
      return w;
   endfunction

   // Negedge monitor: occupancy model, hold rule and in-order scoreboard
   always @(negedge clk) begin
      buf_word_t cur;
      buf_word_t exp_w;
      cur = {m_axis_tlast, m_axis_tstrb, m_axis_tdata};
      if (mon_en) begin
         check("fill_level", 64'(fill_level), 64'(model_cnt));
         check("almost_full", 64'(almost_full), 64'(model_cnt >= AF_TH));
         check("s_tready", 64'(s_axis_tready), 64'(model_cnt < DEPTH));
         if (hold_prev) begin
            check("hold_valid", 64'(m_axis_tvalid), 64'd1);
            check("hold_word", 64'(cur), 64'(prev_word));
         end
      end
      if (!axis_areset) begin
         if (s_axis_tvalid && s_axis_tready) begin
            exp_q.push_back(mk(s_axis_tdata, s_axis_tstrb, s_axis_tlast));
            if (first_acc < 0) first_acc = cyc + 1;
            model_cnt++;
         end
         if (m_axis_tvalid && first_val < 0) first_val = cyc;
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_beat", 64'(exp_q.size()), 64'd1);
            end else begin
               exp_w = exp_q.pop_front();
               check("sb_beat", 64'(cur), 64'(exp_w));
            end
            got_q.push_back(cur);
            model_cnt--;
         end
      end
      hold_prev = !axis_areset && m_axis_tvalid && !m_axis_tready;
      prev_word = cur;
   end

   task automatic send(input buf_word_t w);
      int t;
      t = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = w.tdata;
      s_axis_tstrb  = w.tstrb;
      s_axis_tlast  = w.tlast;
      @(negedge clk);
      while (!s_axis_tready && t < 10000) begin
         @(negedge clk);
         t++;
      end
      if (!s_axis_tready) check("send_timeout", 64'(s_axis_tready), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int max_cyc);
      int t;
      t = 0;
      m_axis_tready = 1'b1;
      while (exp_q.size() != 0 && t < max_cyc) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("drain_done", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      mon_en        = 1'b0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      axis_areset   = 1'b1;
      exp_q.delete();
      got_q.delete();
      model_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      axis_areset = 1'b0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
   endtask

   initial begin
      vec_t t1 [5];
      int   t;

      n_pass = 0; n_total = 0; model_cnt = 0; first_acc = -1; first_val = -1;
      mon_en = 1'b0; hold_prev = 1'b0; prev_word = '0;
      axis_areset = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tstrb = '0;
      s_axis_tlast = 1'b0; m_axis_tready = 1'b0;

      t1[0] = '{32'h000000A0, 4'hF, 1'b0, 32'h000000A0, 4'hF, 1'b0};
      t1[1] = '{32'h000000A1, 4'h1, 1'b0, 32'h000000A1, 4'h1, 1'b0};
      t1[2] = '{32'h000000A2, 4'h3, 1'b0, 32'h000000A2, 4'h3, 1'b0};
      t1[3] = '{32'h000000A3, 4'h0, 1'b0, 32'h000000A3, 4'h0, 1'b0};
      t1[4] = '{32'h000000A4, 4'h8, 1'b1, 32'h000000A4, 4'h8, 1'b1};

      // Reset state
      #1 axis_areset = 1'b1;
      #1;
      check("rst_s_tready", 64'(s_axis_tready), 64'd0);
      check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_fill", 64'(fill_level), 64'd0);
      check("rst_af", 64'(almost_full), 64'd0);
      check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
      repeat (2) @(posedge clk);
      #1 axis_areset = 1'b0;
      @(negedge clk);
      check("rst_tready_before_edge", 64'(s_axis_tready), 64'd0);
      @(posedge clk);
      #1;
      check("rst_tready_after_edge", 64'(s_axis_tready), 64'd1);
      mon_en = 1'b1;

      // Five-beat packet through the vector table
      first_acc = -1; first_val = -1; got_q.delete();
      m_axis_tready = 1'b1;
      for (int i = 0; i < 5; i++) send(mk(t1[i].in_data, t1[i].in_strb, t1[i].in_last));
      s_axis_tvalid = 1'b0;
      drain(50);
      check("t1_count", 64'(got_q.size()), 64'd5);
      for (int i = 0; i < 5; i++)
         if (i < got_q.size())
            check($sformatf("t1_beat%0d", i), 64'(got_q[i]),
                  64'(mk(t1[i].exp_data, t1[i].exp_strb, t1[i].exp_last)));
`ifndef AXIS_BUF_PKT_MODE_EN
      check("t1_latency", 64'(first_val - first_acc), 64'd2);
`endif

      // Fill to DEPTH with the consumer stalled
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         send(mk(32'(i), 4'(i), (i % 16) == 15));
         if (i == AF_TH - 2) check("t2_af_below", 64'(almost_full), 64'd0);
         if (i == AF_TH - 1) check("t2_af_at", 64'(almost_full), 64'd1);
      end
      s_axis_tdata = 32'(DEPTH); s_axis_tstrb = 4'h5; s_axis_tlast = 1'b1;
      check("t2_full_fill", 64'(fill_level), 64'(DEPTH));
      check("t2_full_tready", 64'(s_axis_tready), 64'd0);
      check("t2_full_af", 64'(almost_full), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      check("t2_full_hold", 64'(fill_level), 64'(DEPTH));
      m_axis_tready = 1'b1;
      @(posedge clk);
      #1;
      m_axis_tready = 1'b0;
      check("t2_freed_fill", 64'(fill_level), 64'(DEPTH - 1));
      check("t2_freed_tready", 64'(s_axis_tready), 64'd1);
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      check("t2_refill", 64'(fill_level), 64'(DEPTH));
      check("t2_refill_tready", 64'(s_axis_tready), 64'd0);
      drain(DEPTH + 100);

      // Full-rate concurrent traffic, no bubbles
      do_reset();
      for (int i = 0; i < 8; i++) send(mk($urandom, 4'($urandom), (i % 4) == 3));
      m_axis_tready = 1'b1;
      for (int i = 8; i < 1008; i++) begin
         s_axis_tdata = $urandom; s_axis_tstrb = 4'($urandom); s_axis_tlast = (i % 4) == 3;
         @(negedge clk);
         check("t3_m_tvalid", 64'(m_axis_tvalid), 64'd1);
         check("t3_s_tready", 64'(s_axis_tready), 64'd1);
         check("t3_fill", 64'(fill_level), 64'd8);
         @(posedge clk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      drain(100);

      // Random consumer stalls with gappy producer
      do_reset();
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               s_axis_tvalid = 1'b0;
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               send(mk($urandom, 4'($urandom), (i % 5) == 4));
            end
            s_axis_tvalid = 1'b0;
         end
         begin
            repeat (600) begin
               m_axis_tready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
         end
      join
      drain(300);

      // Reset mid-packet with three beats held
      do_reset();
      for (int i = 0; i < 3; i++) send(mk(32'h11 * 32'(i + 1), 4'hF, 1'b0));
      s_axis_tvalid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("t5_fill_before", 64'(fill_level), 64'd3);
`ifndef AXIS_BUF_PKT_MODE_EN
      check("t5_valid_before", 64'(m_axis_tvalid), 64'd1);
      check("t5_data_before", 64'(m_axis_tdata), 64'h11);
`endif
      mon_en = 1'b0;
      axis_areset = 1'b1;
      #1;
      check("t5_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("t5_rst_m_tdata", 64'(m_axis_tdata), 64'd0);
      check("t5_rst_m_tstrb", 64'(m_axis_tstrb), 64'd0);
      check("t5_rst_s_tready", 64'(s_axis_tready), 64'd0);
      check("t5_rst_fill", 64'(fill_level), 64'd0);
      exp_q.delete(); got_q.delete(); model_cnt = 0;
      @(posedge clk);
      #1 axis_areset = 1'b0;
      @(negedge clk);
      check("t5_tready_low", 64'(s_axis_tready), 64'd0);
      @(posedge clk);
      #1;
      check("t5_tready_high", 64'(s_axis_tready), 64'd1);
      mon_en = 1'b1;
      send(mk(32'h55, 4'hF, 1'b1));
      s_axis_tvalid = 1'b0;
      drain(50);
      check("t5_new_count", 64'(got_q.size()), 64'd1);
      if (got_q.size() > 0) check("t5_new_beat", 64'(got_q[0]), 64'(mk(32'h55, 4'hF, 1'b1)));

`ifdef AXIS_BUF_PKT_MODE_EN
      // Store-and-forward: nothing leaves until the tlast beat is stored
      do_reset();
      m_axis_tready = 1'b1;
      for (int i = 0; i < 3; i++) send(mk(32'hB0 + 32'(i), 4'hF, 1'b0));
      s_axis_tvalid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("t6_gated", 64'(m_axis_tvalid), 64'd0);
      end
      @(posedge clk);
      #1;
      send(mk(32'hB3, 4'hF, 1'b1));
      s_axis_tvalid = 1'b0;
      t = 0;
      @(negedge clk);
      while (!m_axis_tvalid && t < 20) begin
         @(negedge clk);
         t++;
      end
      for (int k = 0; k < 4; k++) begin
         check("t6_burst_valid", 64'(m_axis_tvalid), 64'd1);
         check("t6_burst_data", 64'(m_axis_tdata), 64'(32'hB0 + 32'(k)));
         check("t6_burst_last", 64'(m_axis_tlast), 64'(k == 3));
         @(negedge clk);
      end
      check("t6_after", 64'(m_axis_tvalid), 64'd0);
      @(posedge clk);
      #1;
      drain(20);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
